// File: rtl/switch_event_pkg.sv
// Shared types and helpers for the switch event arbiter and other round-robin blocks.
// Latency: none (declarations and a pure combinational function only).
// Backpressure: not applicable.
package switch_event_pkg;

    localparam int MAX_SWITCHES = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } arb_state_t;

    // Returns the first set bit of 'pending' scanning last+1, last+2, ... with
    // wrap at num-1 -> 0. Offsets are visited from farthest to nearest so the
    // nearest pending index is the one left in 'idx'. When nothing is pending
    // the result is 'last' and the caller must qualify it with |pending.
    function automatic logic [3:0] rr_next(
        input logic [MAX_SWITCHES-1:0] pending,
        input logic [3:0]              last,
        input int                      num
    );
        logic [3:0] idx;
        int         k;
        idx = last;
        for (int off = MAX_SWITCHES; off >= 1; off--) begin
            k = (int'(last) + off) % num;
            if ((off <= num) && pending[k]) begin
                idx = 4'(k);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/switch_event_arbiter_rr_pick.sv
// Round-robin selector: picks the first pending index after 'last', wrapping around.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the pick is consumed.
//
// Ports:
//   pending - request mask, one bit per switch
//   last    - most recently granted index
//   found   - at least one request is pending
//   index   - selected index (equals 'last' when found = 0)
module rr_pick
    import switch_event_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  pending,
    input  logic [IW-1:0] last,
    output logic          found,
    output logic [IW-1:0] index
);

    logic [MAX_SWITCHES-1:0] pend_ext;
    logic [3:0]              last_ext;
    logic [3:0]              pick;

    always_comb begin
        pend_ext         = '0;
        pend_ext[N-1:0]  = pending;
        last_ext         = 4'(last);
        pick             = rr_next(pend_ext, last_ext, N);
        found            = |pending;
        index            = IW'(pick);
    end

endmodule

// File: rtl/switch_event_arbiter.sv
// Collects switch edge events, holds them pending and offers them one at a time, round-robin.
// Latency: edge on i_Switch -> pending bit next clock -> o_Valid one clock later when idle.
// Backpressure: o_Valid/index held while i_Ready=0; further edges stay pending, repeats merge and set o_Overflow.
//
// Ports:
//   i_Clk, i_Rst      - clock, synchronous active-high reset
//   i_Switch          - debounced switch levels, synchronous to i_Clk
//   i_Ready           - consumer accepts the presented event
//   o_Valid, o_Index  - event presented and its switch number
//   o_Rising          - 1 = press, 0 = release
//   o_Overflow        - sticky: an edge merged into an already pending event
//
// Optional feature macro: SWITCH_RELEASE_EVENTS_EN
//   defined   - falling edges become release events (o_Rising = 0)
//   undefined - falling edges are ignored and o_Rising is tied to 1
module switch_event_arbiter #(
    parameter  int NUM_SWITCHES = 4,
    localparam int IDX_W        = $clog2(NUM_SWITCHES)
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst,
    input  logic [NUM_SWITCHES-1:0] i_Switch,
    input  logic                    i_Ready,
    output logic                    o_Valid,
    output logic [IDX_W-1:0]        o_Index,
    output logic                    o_Rising,
    output logic                    o_Overflow
);
    import switch_event_pkg::*;

    arb_state_t              state_q, state_d;
    logic [NUM_SWITCHES-1:0] prev_q, prev_d;
    logic [NUM_SWITCHES-1:0] pend_rise_q, pend_rise_d;
    logic [IDX_W-1:0]        last_q, last_d;   // most recently granted index
    logic [IDX_W-1:0]        index_q, index_d;
    logic                    overflow_q, overflow_d;

    logic [NUM_SWITCHES-1:0] rise_evt;
    logic [NUM_SWITCHES-1:0] clr_rise;
    logic [NUM_SWITCHES-1:0] pend_any;
    logic                    slot_free;
    logic                    grant;
    logic                    found;
    logic [IDX_W-1:0]        pick;

`ifdef SWITCH_RELEASE_EVENTS_EN
    logic [NUM_SWITCHES-1:0] pend_fall_q, pend_fall_d;
    logic [NUM_SWITCHES-1:0] fall_evt;
    logic [NUM_SWITCHES-1:0] clr_fall;
    logic                    rising_q, rising_d;

    assign pend_any = pend_rise_q | pend_fall_q;
`else
    assign pend_any = pend_rise_q;
`endif

    // Rise and fall masks are merged before selection, so one picker suffices.
    rr_pick #(
        .N (NUM_SWITCHES)
    ) u_rr_pick (
        .pending (pend_any),
        .last    (last_q),
        .found   (found),
        .index   (pick)
    );

    always_comb begin
        prev_d     = i_Switch;
        rise_evt   = i_Switch & ~prev_q;
        state_d    = state_q;
        last_d     = last_q;
        index_d    = index_q;
        overflow_d = overflow_q;
        clr_rise   = '0;

        // The output register can take a new event when nothing is presented
        // or the presented one is being accepted this cycle.
        slot_free = (state_q == ST_IDLE) || i_Ready;
        grant     = slot_free && found;

        if (grant) begin
            index_d = pick;
            last_d  = pick;
            state_d = ST_OFFER;
        end else if ((state_q == ST_OFFER) && i_Ready) begin
            state_d = ST_IDLE;
        end

`ifdef SWITCH_RELEASE_EVENTS_EN
        fall_evt = ~i_Switch & prev_q;
        clr_fall = '0;
        rising_d = rising_q;
        if (grant) begin
            // A pending press is always served before a pending release.
            if (pend_rise_q[pick]) begin
                clr_rise[pick] = 1'b1;
                rising_d       = 1'b1;
            end else begin
                clr_fall[pick] = 1'b1;
                rising_d       = 1'b0;
            end
        end
        // A new edge beats the grant's clear: the granted event is the old one.
        pend_fall_d = (pend_fall_q & ~clr_fall) | fall_evt;
        if (|(fall_evt & pend_fall_q & ~clr_fall)) begin
            overflow_d = 1'b1;
        end
`else
        if (grant) begin
            clr_rise[pick] = 1'b1;
        end
`endif

        pend_rise_d = (pend_rise_q & ~clr_rise) | rise_evt;
        if (|(rise_evt & pend_rise_q & ~clr_rise)) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            // Levels present during reset are absorbed and never reported.
            prev_q      <= i_Switch;
            pend_rise_q <= '0;
            last_q      <= IDX_W'(NUM_SWITCHES - 1);
            state_q     <= ST_IDLE;
            index_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            prev_q      <= prev_d;
            pend_rise_q <= pend_rise_d;
            last_q      <= last_d;
            state_q     <= state_d;
            index_q     <= index_d;
            overflow_q  <= overflow_d;
        end
    end

`ifdef SWITCH_RELEASE_EVENTS_EN
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            pend_fall_q <= '0;
            rising_q    <= 1'b1;
        end else begin
            pend_fall_q <= pend_fall_d;
            rising_q    <= rising_d;
        end
    end

    assign o_Rising = rising_q;
`else
    assign o_Rising = 1'b1;
`endif

    assign o_Valid    = (state_q == ST_OFFER);
    assign o_Index    = index_q;
    assign o_Overflow = overflow_q;

endmodule

// File: tb/tb_switch_event_arbiter.sv
// Self-checking bench for switch_event_arbiter: cycle tables plus corner-case sequences.
// Every accepted event is popped from a queue of expected {rising, index} pairs.
// Follows SWITCH_RELEASE_EVENTS_EN to decide whether releases are expected.
module tb_switch_event_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sw;
    logic       rdy;
    logic       o_valid;
    logic [1:0] o_index;
    logic       o_rising;
    logic       o_overflow;

    int n_vec = 0;
    int n_err = 0;

    logic [2:0] exp_q[$];   // {rising, index}

    always #5 clk = ~clk;

    switch_event_arbiter #(
        .NUM_SWITCHES (4)
    ) dut (
        .i_Clk      (clk),
        .i_Rst      (rst),
        .i_Switch   (sw),
        .i_Ready    (rdy),
        .o_Valid    (o_valid),
        .o_Index    (o_index),
        .o_Rising   (o_rising),
        .o_Overflow (o_overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: each handshake is compared with the oldest expected event.
    always @(negedge clk) begin
        if (!rst && o_valid && rdy) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL extra_event: got index %0d rising %0b, expected no event",
                         o_index, o_rising);
            end else begin
                check("event", {29'd0, o_rising, o_index}, {29'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] lvl);
        sw  = lvl;
        rdy = 1'b0;
        rst = 1'b1;
        step();
        step();
        exp_q.delete();
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 50) begin
            step();
            k++;
        end
        check({name, "_drained"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    typedef struct packed {
        logic       rst;
        logic [3:0] sw;
        logic       rdy;
        logic [1:0] push_n;
        logic [5:0] push_idx;   // up to three rising events, first in low bits
        logic       exp_vld;
        logic [1:0] exp_idx;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int bad;

        rst = 1'b1;
        sw  = 4'b0000;
        rdy = 1'b0;

        // Reset with levels held high: no events, reset output values.
        do_reset(4'b0101);
        check("rst_valid",    o_valid,    0);
        check("rst_index",    o_index,    0);
        check("rst_rising",   o_rising,   1);
        check("rst_overflow", o_overflow, 0);
        rdy = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (o_valid !== 1'b0) bad++;
        end
        check("idle_after_reset", bad, 0);
        check("idle_overflow", o_overflow, 0);

        // Single event latency, then a reset and three simultaneous presses.
        tbl[0] = '{rst:1'b0, sw:4'b0100, rdy:1'b1, push_n:2'd1, push_idx:6'd2,          exp_vld:1'b0, exp_idx:2'd0};
        tbl[1] = '{rst:1'b0, sw:4'b0100, rdy:1'b1, push_n:2'd0, push_idx:6'd0,          exp_vld:1'b1, exp_idx:2'd2};
        tbl[2] = '{rst:1'b0, sw:4'b0100, rdy:1'b1, push_n:2'd0, push_idx:6'd0,          exp_vld:1'b0, exp_idx:2'd0};
        tbl[3] = '{rst:1'b0, sw:4'b0100, rdy:1'b1, push_n:2'd0, push_idx:6'd0,          exp_vld:1'b0, exp_idx:2'd0};
        tbl[4] = '{rst:1'b1, sw:4'b0100, rdy:1'b1, push_n:2'd0, push_idx:6'd0,          exp_vld:1'b0, exp_idx:2'd0};
        tbl[5] = '{rst:1'b0, sw:4'b1111, rdy:1'b1, push_n:2'd3, push_idx:6'b11_01_00,   exp_vld:1'b0, exp_idx:2'd0};
        tbl[6] = '{rst:1'b0, sw:4'b1111, rdy:1'b1, push_n:2'd0, push_idx:6'd0,          exp_vld:1'b1, exp_idx:2'd0};
        tbl[7] = '{rst:1'b0, sw:4'b1111, rdy:1'b1, push_n:2'd0, push_idx:6'd0,          exp_vld:1'b1, exp_idx:2'd1};
        tbl[8] = '{rst:1'b0, sw:4'b1111, rdy:1'b1, push_n:2'd0, push_idx:6'd0,          exp_vld:1'b1, exp_idx:2'd3};
        tbl[9] = '{rst:1'b0, sw:4'b1111, rdy:1'b1, push_n:2'd0, push_idx:6'd0,          exp_vld:1'b0, exp_idx:2'd0};

        do_reset(4'b0000);
        for (int i = 0; i < 10; i++) begin
            rst = tbl[i].rst;
            sw  = tbl[i].sw;
            rdy = tbl[i].rdy;
            for (int j = 0; j < int'(tbl[i].push_n); j++) begin
                exp_q.push_back({1'b1, tbl[i].push_idx[2*j +: 2]});
            end
            step();
            check($sformatf("tbl%0d_valid", i), o_valid, tbl[i].exp_vld);
            if (tbl[i].exp_vld) begin
                check($sformatf("tbl%0d_index", i), o_index, tbl[i].exp_idx);
            end
        end
        rst = 1'b0;
        drain("tbl");

        // Backpressure: switch 1 held for 10 cycles, switch 0 queued behind it.
        do_reset(4'b0000);
        sw = 4'b0010;
        exp_q.push_back(3'b101);
        step();
        check("hold_pend_valid", o_valid, 0);
        step();
        for (int i = 0; i < 10; i++) begin
            check("hold_valid", o_valid, 1);
            check("hold_index", o_index, 1);
            if (i == 3) begin
                sw = 4'b0011;
                exp_q.push_back(3'b100);
            end
            step();
        end
        rdy = 1'b1;
        step();
        check("hold_next_valid", o_valid, 1);
        check("hold_next_index", o_index, 0);
        drain("hold");

        // Switch 3 rises, falls and rises while pending: merged, sticky overflow.
        do_reset(4'b0000);
        sw = 4'b0100;
        exp_q.push_back(3'b110);
        step();
        step();
        sw = 4'b1100;
        exp_q.push_back(3'b111);
        step();
        step();
        sw = 4'b0100;
`ifdef SWITCH_RELEASE_EVENTS_EN
        exp_q.push_back(3'b011);
`endif
        step();
        step();
        check("ovf_before", o_overflow, 0);
        sw = 4'b1100;
        step();
        check("ovf_set", o_overflow, 1);
        check("ovf_hold_index", o_index, 2);
        rdy = 1'b1;
        drain("ovf");
        step();
        step();
        step();
        check("ovf_idle_valid", o_valid, 0);
        check("ovf_sticky", o_overflow, 1);
        do_reset(4'b1100);
        check("ovf_cleared", o_overflow, 0);

        // New edge on the index granted in the same cycle: set wins, no overflow.
        do_reset(4'b0000);
        sw = 4'b0100;
        exp_q.push_back(3'b110);
        step();
        step();
        sw = 4'b1100;
        exp_q.push_back(3'b111);
        step();
        step();
        sw = 4'b0100;
        step();
        sw  = 4'b1100;
        rdy = 1'b1;
        exp_q.push_back(3'b111);
`ifdef SWITCH_RELEASE_EVENTS_EN
        exp_q.push_back(3'b011);
`endif
        step();
        check("setwin_valid", o_valid, 1);
        check("setwin_index", o_index, 3);
        drain("setwin");
        check("setwin_overflow", o_overflow, 0);

        // Press then release switch 1 with the consumer always ready.
        do_reset(4'b0000);
        rdy = 1'b1;
        sw  = 4'b0010;
        exp_q.push_back(3'b101);
        step();
        step();
        step();
        sw = 4'b0000;
`ifdef SWITCH_RELEASE_EVENTS_EN
        exp_q.push_back(3'b001);
`endif
        step();
        step();
        step();
        step();
        drain("release");
        step();
        step();
        check("release_idle", o_valid, 0);

        // Reset while an event is presented discards it and everything pending.
        do_reset(4'b0000);
        sw = 4'b0011;
        exp_q.push_back(3'b100);
        exp_q.push_back(3'b101);
        step();
        step();
        check("midrst_offered", o_valid, 1);
        do_reset(4'b0011);
        check("midrst_valid", o_valid, 0);
        rdy = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (o_valid !== 1'b0) bad++;
        end
        check("midrst_quiet", bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/switch_event_arbiter.md
Name: switch_event_arbiter

Overview:
Collects edge events from NUM_SWITCHES debounced switch lines and holds each event pending until it is delivered. Events are presented one at a time to a single consumer through a valid/ready handshake. Pending events are served round-robin, so a busy switch cannot starve the others. The block sits between the per-switch debounce filters and the application logic (LED/segment control, game FSMs).

Parameters:
NUM_SWITCHES, 4, number of debounced inputs; legal range 2..16
IDX_W, $clog2(NUM_SWITCHES), width of the event index; derived, not overridden

Ports:
i_Clk  input  1  system clock
i_Rst  input  1  synchronous, active-high reset
i_Switch  input  NUM_SWITCHES  debounced switch levels, already synchronous to i_Clk
i_Ready  input  1  consumer accepts the presented event this cycle
o_Valid  output  1  an event is presented
o_Index  output  IDX_W  switch number of the presented event
o_Rising  output  1  1 = press (rising edge), 0 = release (falling edge)
o_Overflow  output  1  sticky flag: an edge arrived while the same event was still pending

Behaviour:
- Reset (i_Rst high at a clock edge):
  - r_Prev loads i_Switch, so levels present at reset produce no events.
  - All pending bits clear.
  - Round-robin pointer r_Last = NUM_SWITCHES-1, so index 0 is checked first.
  - Outputs: o_Valid=0, o_Index=0, o_Rising=1, o_Overflow=0.
  - Reset mid-handshake discards the presented event and all pending events.
- Edge detect: rise[k] = i_Switch[k] & ~r_Prev[k]. r_Prev <= i_Switch every cycle. A detected edge sets pend_rise[k] on the next clock.
- FSM states:
  - IDLE: o_Valid=0. If any bit is pending, select the first pending index scanning r_Last+1, r_Last+2, ... with wrap at NUM_SWITCHES-1 -> 0. Register o_Index and o_Rising, clear the selected pending bit, set r_Last to the selected index, go to OFFER.
  - OFFER: o_Valid=1. o_Index and o_Rising are held stable while i_Ready=0. On a handshake (o_Valid & i_Ready):
    - if another event is pending, select it with the same rule in the same cycle and stay in OFFER (back-to-back, one event per clock);
    - otherwise go to IDLE and drop o_Valid on the next cycle.
- Latency: an input edge at clock t sets the pending bit at t+1. When the block is idle, o_Valid rises at t+2.
- Simultaneous events:
  - A new edge on the index being granted in the same cycle: the grant takes the old event and the pending bit stays set (set wins over clear). The new event is served later.
  - A new edge on an index whose bit is already pending and not being cleared: the pending bit stays 1, the event is merged, and o_Overflow sets to 1 and stays 1 until reset.
  - Several bits pending: strict round-robin order starting after r_Last.
- Without a handshake, an event is never lost or reordered except through overflow merging.

Optional Feature:
- Macro: SWITCH_RELEASE_EVENTS_EN.
- Defined:
  - Falling edges (~i_Switch[k] & r_Prev[k]) set a separate pend_fall[k], with its own overflow detection.
  - The round-robin scan covers index k if pend_rise[k] or pend_fall[k] is set.
  - If both are set for the granted index, the rise is granted first and the fall stays pending.
  - o_Rising reports the type of the granted event.
- Undefined: pend_fall logic is absent, o_Rising is tied to 1, and falling edges are ignored.

Decomposition:
- Package switch_event_pkg:
  - FSM state encoding (ST_IDLE, ST_OFFER);
  - MAX_SWITCHES=16;
  - function rr_next(pending, last) returning the next index, shared with other round-robin blocks.
- Sub-module rr_pick: combinational, one-hot-free round-robin selector. Inputs: pending mask and r_Last. Outputs: found and index. Instantiated once; a second instance is not required because rise and fall masks are ORed before selection.

Test Plan:
- Reset with i_Switch=4'b0101 held, then release reset -> o_Valid stays 0 for 20 cycles; o_Overflow=0.
- Switch 2 rises at cycle t, i_Ready=1 -> o_Valid=1 at t+2 with o_Index=2 and o_Rising=1 for exactly one cycle.
- Switches 0, 1 and 3 rise in the same cycle, i_Ready=1, r_Last=3 after reset -> o_Index sequence 0, 1, 3 on three consecutive cycles, o_Valid continuous.
- i_Ready=0 for 10 cycles while switch 1 is presented -> o_Index=1 held stable and o_Valid=1 throughout; a later switch 0 edge is delivered only after the switch 1 handshake.
- Switch 3 rises, falls and rises again while i_Ready=0 and its event is pending -> a single index-3 event is delivered and o_Overflow=1 sticky; i_Rst pulse clears it to 0.
- With SWITCH_RELEASE_EVENTS_EN, press then release switch 1 with i_Ready=1 -> two events (1, o_Rising=1) then (1, o_Rising=0). Without the macro, only the first event is delivered.
